// File: rtl/vending_dispense_scheduler_if.sv
// Coin hopper handshake: level eject_req with a stable eject_val until hopper_ack.
// master = scheduler (drives req/val), slave = hopper (drives ack).
interface vending_dispense_scheduler_if;
  logic eject_req;
  logic eject_val;
  logic hopper_ack;

  modport master (
    output eject_req,
    output eject_val,
    input  hopper_ack
  );

  modport slave (
    input  eject_req,
    input  eject_val,
    output hopper_ack
  );
endinterface

// File: rtl/vending_dispense_scheduler.sv
// Two-item vending sequencer: credit, stock, selection, dispense pulse, coin refund.
// Ports: clk, rst (async active-low), coin/sel/cancel/restock inputs, hop (hopper
// master), dispense_A/B, coin_reject, sel_err, credit, sold_out_A/B, busy.
module vending_dispense_scheduler #(
  parameter int PRICE_A    = 10,
  parameter int PRICE_B    = 15,
  parameter int CREDIT_MAX = 30,
  parameter int STOCK_MAX  = 4,
  parameter int STOCK_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic       sel_item,
  input  logic       cancel,
  input  logic       restock_A,
  input  logic       restock_B,
  vending_dispense_scheduler_if.master hop,
  output logic       dispense_A,
  output logic       dispense_B,
  output logic       coin_reject,
  output logic       sel_err,
  output logic [5:0] credit,
  output logic       sold_out_A,
  output logic       sold_out_B,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [5:0] PA   = 6'(PRICE_A);
  localparam logic [5:0] PB   = 6'(PRICE_B);
  localparam logic [6:0] CMAX = 7'(CREDIT_MAX);
  localparam logic [STOCK_W-1:0] SMAX = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W-1:0] ONE  = STOCK_W'(1);

  state_t state, state_n;
  logic [5:0] credit_n;
  logic [STOCK_W-1:0] stock_a, stock_b;
  logic [STOCK_W-1:0] stock_a_n, stock_b_n;
  logic disp_a_n, disp_b_n, rej_n, err_n;
  logic req_n, val_n;
  logic [6:0] coin_amt;
  logic [6:0] sum;
  logic [5:0] price;
  logic [STOCK_W-1:0] stock_sel;

  always_comb begin
    coin_amt = 7'd0;
    case (coin)
      2'b01:   coin_amt = 7'd5;
      2'b10:   coin_amt = 7'd10;
      default: coin_amt = 7'd0;
    endcase
  end

  assign sum       = {1'b0, credit} + coin_amt;
  assign price     = sel_item ? PB : PA;
  assign stock_sel = sel_item ? stock_b : stock_a;

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    stock_a_n = stock_a;
    stock_b_n = stock_b;
    disp_a_n  = 1'b0;
    disp_b_n  = 1'b0;
    rej_n     = 1'b0;
    err_n     = 1'b0;
    req_n     = hop.eject_req;
    val_n     = hop.eject_val;
    unique case (state)
      IDLE, COLLECT: begin
        if (coin_amt != 7'd0) begin
          if (sum <= CMAX) begin
            credit_n = sum[5:0];
            if (state == IDLE) state_n = COLLECT;
          end else begin
            rej_n = 1'b1;
          end
        end
        // cancel masks a same-cycle selection, even in IDLE
        if (cancel) begin
          if (state == COLLECT) begin
            state_n = CHANGE;
            req_n   = 1'b1;
            val_n   = (credit_n >= 6'd10);
          end
        end else if (sel_valid) begin
          if (stock_sel == '0 || credit_n < price) begin
            err_n = 1'b1;
          end else begin
            state_n  = VEND;
            credit_n = credit_n - price;
            if (sel_item) begin
              stock_b_n = stock_b - ONE;
              disp_b_n  = 1'b1;
            end else begin
              stock_a_n = stock_a - ONE;
              disp_a_n  = 1'b1;
            end
          end
        end
      end
      VEND: begin
        rej_n = (coin_amt != 7'd0);
        if (credit != 6'd0) begin
          state_n = CHANGE;
          req_n   = 1'b1;
          val_n   = (credit >= 6'd10);
        end else begin
          state_n = IDLE;
        end
      end
      CHANGE: begin
        rej_n = (coin_amt != 7'd0);
        if (hop.eject_req) begin
          if (hop.hopper_ack) begin
            credit_n = credit - (hop.eject_val ? 6'd10 : 6'd5);
            req_n    = 1'b0;
            if (credit_n == 6'd0) state_n = IDLE;
          end
        end else if (credit != 6'd0) begin
          // one idle cycle after each ack before the next request
          req_n = 1'b1;
          val_n = (credit >= 6'd10);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (restock_A) stock_a_n = SMAX;
    if (restock_B) stock_b_n = SMAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      credit        <= 6'd0;
      stock_a       <= SMAX;
      stock_b       <= SMAX;
      dispense_A    <= 1'b0;
      dispense_B    <= 1'b0;
      coin_reject   <= 1'b0;
      sel_err       <= 1'b0;
      hop.eject_req <= 1'b0;
      hop.eject_val <= 1'b0;
      sold_out_A    <= 1'b0;
      sold_out_B    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      stock_a       <= stock_a_n;
      stock_b       <= stock_b_n;
      dispense_A    <= disp_a_n;
      dispense_B    <= disp_b_n;
      coin_reject   <= rej_n;
      sel_err       <= err_n;
      hop.eject_req <= req_n;
      hop.eject_val <= val_n;
      sold_out_A    <= (stock_a_n == '0);
      sold_out_B    <= (stock_b_n == '0);
      busy          <= (state_n == VEND) || (state_n == CHANGE);
    end
  end

endmodule

// File: tb/tb_vending_dispense_scheduler.sv
// Scoreboard bench for vending_dispense_scheduler.
// Expected dispenses/ejects are queued at stimulus time, popped on DUT output.
module tb_vending_dispense_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic       sel_item = 1'b0;
  logic       cancel = 1'b0;
  logic       restock_A = 1'b0;
  logic       restock_B = 1'b0;
  logic       dispense_A, dispense_B, coin_reject, sel_err;
  logic [5:0] credit;
  logic       sold_out_A, sold_out_B, busy;

  vending_dispense_scheduler_if hif ();

  vending_dispense_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .coin       (coin),
    .sel_valid  (sel_valid),
    .sel_item   (sel_item),
    .cancel     (cancel),
    .restock_A  (restock_A),
    .restock_B  (restock_B),
    .hop        (hif),
    .dispense_A (dispense_A),
    .dispense_B (dispense_B),
    .coin_reject(coin_reject),
    .sel_err    (sel_err),
    .credit     (credit),
    .sold_out_A (sold_out_A),
    .sold_out_B (sold_out_B),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit exp_disp[$];
  bit exp_ej[$];
  int exp_credit = 0;
  int stock_a = 4;
  int stock_b = 4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c, input bit rej);
    coin = c;
    tick();
    coin = 2'b00;
    n_chk++;
    if (coin_reject !== rej) begin
      n_fail++;
      $display("FAIL coin_reject code=%b got=%b want=%b", c, coin_reject, rej);
    end
    if (!rej && c == 2'b01) exp_credit += 5;
    if (!rej && c == 2'b10) exp_credit += 10;
    n_chk++;
    if (credit !== 6'(exp_credit)) begin
      n_fail++;
      $display("FAIL coin_credit got=%0d want=%0d", credit, exp_credit);
    end
  endtask

  task automatic drain_dispense();
    int k;
    bit it;
    k = 0;
    while (!(dispense_A || dispense_B) && k < 4) begin
      tick();
      k++;
    end
    n_chk++;
    if (k == 4 || exp_disp.size() == 0) begin
      n_fail++;
      $display("FAIL dispense_timeout got=none want=pulse");
      exp_disp.delete();
    end else begin
      it = exp_disp.pop_front();
      if ({dispense_B, dispense_A} !== (it ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL dispense_item got=%b want=%b",
                 {dispense_B, dispense_A}, (it ? 2'b10 : 2'b01));
      end
    end
  endtask

  task automatic select(input bit item, input bit ok);
    if (ok) begin
      exp_disp.push_back(item);
      exp_credit -= item ? 15 : 10;
      if (item) stock_b--;
      else stock_a--;
    end
    sel_valid = 1'b1;
    sel_item  = item;
    tick();
    sel_valid = 1'b0;
    n_chk++;
    if (sel_err !== !ok) begin
      n_fail++;
      $display("FAIL sel_err got=%b want=%b", sel_err, !ok);
    end
    if (ok) drain_dispense();
    n_chk++;
    if (credit !== 6'(exp_credit)) begin
      n_fail++;
      $display("FAIL sel_credit got=%0d want=%0d", credit, exp_credit);
    end
  endtask

  task automatic drain_ejects(input bit stray);
    int k;
    bit v;
    while (exp_ej.size() > 0) begin
      k = 0;
      while (!hif.eject_req && k < 8) begin
        tick();
        k++;
      end
      n_chk++;
      if (k == 8) begin
        n_fail++;
        $display("FAIL eject_timeout got=none want=eject_req");
        exp_ej.delete();
        break;
      end
      v = exp_ej.pop_front();
      if (hif.eject_val !== v) begin
        n_fail++;
        $display("FAIL eject_val got=%b want=%b", hif.eject_val, v);
      end
      tick();
      n_chk++;
      if (hif.eject_req !== 1'b1 || hif.eject_val !== v) begin
        n_fail++;
        $display("FAIL eject_hold got=%b/%b want=1/%b",
                 hif.eject_req, hif.eject_val, v);
      end
      hif.hopper_ack = 1'b1;
      tick();
      hif.hopper_ack = 1'b0;
      exp_credit -= v ? 10 : 5;
      n_chk++;
      if (hif.eject_req !== 1'b0 || credit !== 6'(exp_credit)) begin
        n_fail++;
        $display("FAIL eject_ack got=req%b/cr%0d want=req0/cr%0d",
                 hif.eject_req, credit, exp_credit);
      end
      if (stray && exp_ej.size() > 0) begin
        hif.hopper_ack = 1'b1;
        tick();
        hif.hopper_ack = 1'b0;
        n_chk++;
        if (credit !== 6'(exp_credit)) begin
          n_fail++;
          $display("FAIL stray_ack got=%0d want=%0d", credit, exp_credit);
        end
      end
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || credit !== 6'd0 || hif.eject_req !== 1'b0) begin
      n_fail++;
      $display("FAIL change_done got=busy%b/cr%0d/req%b want=busy0/cr0/req0",
               busy, credit, hif.eject_req);
    end
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || hif.eject_req !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_entry got=busy%b/req%b want=busy1/req1",
               busy, hif.eject_req);
    end
  endtask

  task automatic idle_check();
    tick();
    n_chk++;
    if (busy !== 1'b0 || hif.eject_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle got=busy%b/req%b want=busy0/req0", busy, hif.eject_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hif.hopper_ack = 1'b0;
    repeat (2) tick();
    n_chk++;
    if ({credit, busy, hif.eject_req, hif.eject_val, dispense_A, dispense_B,
         sold_out_A, sold_out_B, coin_reject, sel_err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state got=cr%0d busy%b req%b want=all zero",
               credit, busy, hif.eject_req);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_sale();
    put_coin(2'b10, 1'b0);
    select(1'b0, 1'b1);
    idle_check();
  endtask

  task automatic test_sale_with_change();
    put_coin(2'b10, 1'b0);
    put_coin(2'b10, 1'b0);
    select(1'b1, 1'b1);
    exp_ej.push_back(1'b0);
    drain_ejects(1'b0);
  endtask

  task automatic test_cancel_refund();
    repeat (3) put_coin(2'b10, 1'b0);
    put_coin(2'b01, 1'b1);
    put_coin(2'b11, 1'b0);
    do_cancel();
    repeat (3) exp_ej.push_back(1'b1);
    drain_ejects(1'b1);
  endtask

  task automatic test_sold_out();
    while (stock_a > 0) begin
      put_coin(2'b10, 1'b0);
      select(1'b0, 1'b1);
      idle_check();
    end
    n_chk++;
    if (sold_out_A !== 1'b1 || sold_out_B !== 1'b0) begin
      n_fail++;
      $display("FAIL sold_out got=%b%b want=10", sold_out_A, sold_out_B);
    end
    put_coin(2'b10, 1'b0);
    select(1'b0, 1'b0);
    restock_A = 1'b1;
    tick();
    restock_A = 1'b0;
    stock_a = 4;
    n_chk++;
    if (sold_out_A !== 1'b0) begin
      n_fail++;
      $display("FAIL restock got=%b want=0", sold_out_A);
    end
    select(1'b0, 1'b1);
    idle_check();
  endtask

  task automatic test_busy_coin_and_short_credit();
    put_coin(2'b10, 1'b0);
    put_coin(2'b10, 1'b0);
    do_cancel();
    put_coin(2'b10, 1'b1);
    repeat (2) exp_ej.push_back(1'b1);
    drain_ejects(1'b0);
    put_coin(2'b01, 1'b0);
    select(1'b1, 1'b0);
    do_cancel();
    exp_ej.push_back(1'b0);
    drain_ejects(1'b0);
  endtask

  task automatic test_cancel_wins();
    put_coin(2'b10, 1'b0);
    put_coin(2'b01, 1'b0);
    cancel    = 1'b1;
    sel_valid = 1'b1;
    sel_item  = 1'b0;
    tick();
    cancel    = 1'b0;
    sel_valid = 1'b0;
    n_chk++;
    if ({dispense_A, dispense_B, sel_err} !== 3'b000 || hif.eject_req !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_wins got=dA%b dB%b err%b req%b want=0 0 0 1",
               dispense_A, dispense_B, sel_err, hif.eject_req);
    end
    exp_ej.push_back(1'b1);
    exp_ej.push_back(1'b0);
    drain_ejects(1'b0);
  endtask

  task automatic test_coin_with_select_and_reset();
    put_coin(2'b10, 1'b0);
    exp_disp.push_back(1'b1);
    exp_credit = 0;
    stock_b--;
    coin      = 2'b01;
    sel_valid = 1'b1;
    sel_item  = 1'b1;
    tick();
    coin      = 2'b00;
    sel_valid = 1'b0;
    n_chk++;
    if (coin_reject !== 1'b0 || credit !== 6'd0 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_plus_sel got=rej%b cr%0d err%b want=rej0 cr0 err0",
               coin_reject, credit, sel_err);
    end
    drain_dispense();
    idle_check();
    put_coin(2'b10, 1'b0);
    put_coin(2'b10, 1'b0);
    select(1'b0, 1'b1);
    tick();
    n_chk++;
    if (hif.eject_req !== 1'b1 || hif.eject_val !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_eject got=%b/%b want=1/1",
               hif.eject_req, hif.eject_val);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (hif.eject_req !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got=req%b cr%0d busy%b want=req0 cr0 busy0",
               hif.eject_req, credit, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_credit = 0;
    stock_a = 4;
    stock_b = 4;
    idle_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_sale();
    test_sale_with_change();
    test_cancel_refund();
    test_sold_out();
    test_busy_coin_and_short_credit();
    test_cancel_wins();
    test_coin_with_select_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
